// File: rtl/det3_seq_pkg.sv
// det3_seq_pkg: shared constants, state encoding and term table for the
// sequential 3x3 determinant engine.
//   DATA_W  - signed element / result width
//   ACC_W   - signed accumulator width (>= DATA_W+3)
//   N_STEPS - multiply steps per determinant (two per term, six terms)
package det3_seq_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 12;
  localparam int N_STEPS = 12;
  localparam int M_W     = 9 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Register-level encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_MUL  = 2'(MUL);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  // Element indices, row-major: idx = 3*r + c.
  localparam logic [3:0] A00 = 4'd0, A01 = 4'd1, A02 = 4'd2;
  localparam logic [3:0] A10 = 4'd3, A11 = 4'd4, A12 = 4'd5;
  localparam logic [3:0] A20 = 4'd6, A21 = 4'd7, A22 = 4'd8;

  // Term table: det = sum over t of sign(t) * x(t) * y(t) * z(t).
  function automatic logic [3:0] term_x(input logic [2:0] t);
    case (t)
      3'd0:    term_x = A00;
      3'd1:    term_x = A01;
      3'd2:    term_x = A02;
      3'd3:    term_x = A01;
      3'd4:    term_x = A00;
      3'd5:    term_x = A02;
      default: term_x = A00;
    endcase
  endfunction

  function automatic logic [3:0] term_y(input logic [2:0] t);
    case (t)
      3'd0:    term_y = A11;
      3'd1:    term_y = A12;
      3'd2:    term_y = A10;
      3'd3:    term_y = A10;
      3'd4:    term_y = A12;
      3'd5:    term_y = A11;
      default: term_y = A00;
    endcase
  endfunction

  function automatic logic [3:0] term_z(input logic [2:0] t);
    case (t)
      3'd0:    term_z = A22;
      3'd1:    term_z = A20;
      3'd2:    term_z = A21;
      3'd3:    term_z = A22;
      3'd4:    term_z = A21;
      3'd5:    term_z = A20;
      default: term_z = A00;
    endcase
  endfunction

  // 1 = subtract the term from the accumulator.
  function automatic logic term_neg(input logic [2:0] t);
    term_neg = (t == 3'd3) || (t == 3'd4) || (t == 3'd5);
  endfunction

  // Extract element idx from a packed matrix (a00 in the MSBs).
  function automatic logic signed [DATA_W-1:0] elem(input logic [M_W-1:0] mat,
                                                    input logic [3:0] idx);
    elem = '0;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) elem = mat[M_W-1-DATA_W*i -: DATA_W];
    end
  endfunction

  // True when an accumulator value is representable in DATA_W signed bits.
  function automatic logic acc_fits(input logic signed [ACC_W-1:0] v);
    acc_fits = (v[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){v[DATA_W-1]}});
  endfunction

endpackage

// File: rtl/det3_seq_if.sv
// det3_seq_if: request/result bundle between the instruction decoder
// (master) and the determinant engine (slave).
//   start - request, honoured only while ready=1
//   m     - packed row-major matrix, a00 in the MSBs
//   ready - engine idle
//   busy  - engine multiplying
//   done  - one-cycle pulse, det/ovf updated
//   det   - signed determinant, low DATA_W bits
//   ovf   - overflow of the last completed determinant
interface det3_seq_if
  import det3_seq_pkg::*;
();
  logic                     start;
  logic [M_W-1:0]           m;
  logic                     ready;
  logic                     busy;
  logic                     done;
  logic signed [DATA_W-1:0] det;
  logic                     ovf;

  modport master (output start, m, input ready, busy, done, det, ovf);
  modport slave  (input start, m, output ready, busy, done, det, ovf);
endinterface

// File: rtl/det_mul_unit.sv
// det_mul_unit: combinational DATA_W x DATA_W signed multiplier.
//   a, b - signed operands
//   prod - product truncated to DATA_W bits
//   ovf  - full product not representable in DATA_W signed bits
module det_mul_unit
  import det3_seq_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] prod,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] full;

  assign full = a * b;
  assign prod = full[DATA_W-1:0];
  // In range only if every bit above the truncated sign bit repeats it.
  assign ovf  = (full[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){full[DATA_W-1]}});

endmodule

// File: rtl/det3_seq.sv
// det3_seq: sequential 3x3 signed determinant, one shared multiplier,
// twelve steps per matrix (x*y on even steps, partial*z on odd steps).
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - det3_seq_if slave: start/m in, ready/busy/done/det/ovf out
//
// state | meaning
// IDLE  | ready=1, waiting for start; m latched on acceptance
// MUL   | busy=1, step 0..11 through the term table
// DONE  | done=1 for one cycle, det/ovf just updated
module det3_seq
  import det3_seq_pkg::*;
(
  input logic      clk,
  input logic      rst,
  det3_seq_if.slave bus
);

  logic [1:0]               state;
  logic [3:0]               step;
  logic [M_W-1:0]           m_q;
  logic signed [DATA_W-1:0] partial;
  logic signed [ACC_W-1:0]  acc;
  logic                     sticky_ovf;
  logic signed [DATA_W-1:0] det_q;
  logic                     ovf_q;

  logic [2:0]               t;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [DATA_W-1:0] prod;
  logic                     mul_ovf;
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W-1:0]  acc_step;
  logic                     sticky_step;

  assign t = step[3:1];

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == ST_MUL) begin
      if (step[0]) begin
        op_a = partial;
        op_b = elem(m_q, term_z(t));
      end else begin
        op_a = elem(m_q, term_x(t));
        op_b = elem(m_q, term_y(t));
      end
    end
  end

  det_mul_unit u_mul (
    .a    (op_a),
    .b    (op_b),
    .prod (prod),
    .ovf  (mul_ovf)
  );

  assign p_ext       = {{(ACC_W-DATA_W){prod[DATA_W-1]}}, prod};
  assign acc_step    = term_neg(t) ? (acc - p_ext) : (acc + p_ext);
  assign sticky_step = sticky_ovf | mul_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      step       <= '0;
      m_q        <= '0;
      partial    <= '0;
      acc        <= '0;
      sticky_ovf <= 1'b0;
      det_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            m_q        <= bus.m;
            acc        <= '0;
            sticky_ovf <= 1'b0;
            step       <= '0;
            state      <= ST_MUL;
          end
        end
        ST_MUL: begin
          sticky_ovf <= sticky_step;
          if (step[0]) acc <= acc_step;
          else         partial <= prod;
          // Last step is odd, so acc_step already holds the final sum; capture
          // it here so det/ovf are valid in the same cycle done is high.
          if (step == 4'(N_STEPS - 1)) begin
            det_q <= acc_step[DATA_W-1:0];
            ovf_q <= sticky_step | ~acc_fits(acc_step);
            step  <= '0;
            state <= ST_DONE;
          end else begin
            step <= step + 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.busy  = (state == ST_MUL);
  assign bus.done  = (state == ST_DONE);
  assign bus.det   = det_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_det3_seq.sv
// tb_det3_seq: directed self-checking bench for det3_seq.
// Inputs change and outputs are sampled on the falling edge. "k" counts
// falling edges after the edge that accepts start (k=1 is cycle T+1).
module tb_det3_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  det3_seq_if bus ();

  det3_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [71:0] M_ID  = {8'h01,8'h00,8'h00, 8'h00,8'h01,8'h00, 8'h00,8'h00,8'h01};
  localparam logic [71:0] M_A   = {8'h02,8'h01,8'h00, 8'h01,8'h03,8'h01, 8'h00,8'h01,8'h02};
  localparam logic [71:0] M_SEQ = {8'h01,8'h02,8'h03, 8'h04,8'h05,8'h06, 8'h07,8'h08,8'h0A};
  localparam logic [71:0] M_MIN = {8'h80,8'h00,8'h00, 8'h00,8'h01,8'h00, 8'h00,8'h00,8'h01};

  // Issue one request and wait (bounded) for done. Ends on the falling edge
  // one cycle after done, where ready should be back.
  task automatic run_op(input logic [71:0] mat, output logic [7:0] d, output logic o,
                        output int lat, output int ready_bad);
    int k;
    @(negedge clk);
    bus.start = 1'b1;
    bus.m     = mat;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1; lat = -1; ready_bad = 0; d = 8'h00; o = 1'b0;
    while (lat < 0 && k <= 40) begin
      if (bus.done === 1'b1) begin
        lat = k; d = bus.det; o = bus.ovf;
      end else begin
        if (bus.ready !== 1'b0) ready_bad++;
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.m = '0;
    repeat (3) @(negedge clk);
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    tests++; if (bus.busy  !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done  !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.det   !== 8'h00) begin fails++; $display("FAIL reset_det got %h want 00", bus.det); end
    tests++; if (bus.ovf   !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    logic [7:0] d; logic o; int lat, rb;
    run_op(M_ID, d, o, lat, rb);
    tests++; if (lat !== 13) begin fails++; $display("FAIL id_latency got %0d want 13", lat); end
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL id_det got %h want 01", d); end
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL id_ovf got %b want 0", o); end
    tests++; if (rb !== 0) begin fails++; $display("FAIL id_ready_low got %0d high cycles want 0", rb); end
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL id_ready_t14 got %b want 1", bus.ready); end
    repeat (3) @(negedge clk);
    tests++; if (bus.det !== 8'h01 || bus.ovf !== 1'b0) begin
      fails++; $display("FAIL id_hold got det=%h ovf=%b want det=01 ovf=0", bus.det, bus.ovf);
    end
  endtask

  task automatic test_matrices();
    logic [71:0] mats [8];
    logic [7:0]  exp_d [8];
    logic        exp_o [8];
    logic [7:0]  d; logic o; int lat, rb;
    mats[0] = M_A;   exp_d[0] = 8'h08; exp_o[0] = 1'b0;
    mats[1] = {8'hFF,8'h00,8'h00, 8'h00,8'h05,8'h00, 8'h00,8'h00,8'h05}; exp_d[1] = 8'hE7; exp_o[1] = 1'b0;
    mats[2] = {8'h10,8'h00,8'h00, 8'h00,8'h10,8'h00, 8'h00,8'h00,8'h10}; exp_d[2] = 8'h00; exp_o[2] = 1'b1;
    mats[3] = {8'h05,8'h02,8'h00, 8'h00,8'h05,8'h02, 8'h02,8'h00,8'h05}; exp_d[3] = 8'h85; exp_o[3] = 1'b1;
    mats[4] = M_SEQ; exp_d[4] = 8'hFD; exp_o[4] = 1'b0;
    mats[5] = M_MIN; exp_d[5] = 8'h80; exp_o[5] = 1'b0;
    mats[6] = {8'h7F,8'h00,8'h00, 8'h00,8'h01,8'h00, 8'h00,8'h00,8'h01}; exp_d[6] = 8'h7F; exp_o[6] = 1'b0;
    mats[7] = {8'h80,8'h00,8'h00, 8'h00,8'hFF,8'h00, 8'h00,8'h00,8'h01}; exp_d[7] = 8'h80; exp_o[7] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(mats[i], d, o, lat, rb);
      tests++; if (lat !== 13 || d !== exp_d[i]) begin
        fails++; $display("FAIL mat%0d_det got %h (lat %0d) want %h (lat 13)", i, d, lat, exp_d[i]);
      end
      tests++; if (o !== exp_o[i]) begin
        fails++; $display("FAIL mat%0d_ovf got %b want %b", i, o, exp_o[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0, lat = -1;
    logic [7:0] d = 8'h00;
    @(negedge clk);
    bus.start = 1'b1; bus.m = M_A;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = k; d = bus.det; end
      end
      if (k == 5) begin bus.start = 1'b1; bus.m = M_ID; end
      if (k == 6) bus.start = 1'b0;
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL ign_done_count got %0d want 1", ndone); end
    tests++; if (lat !== 13) begin fails++; $display("FAIL ign_latency got %0d want 13", lat); end
    tests++; if (d !== 8'h08) begin fails++; $display("FAIL ign_det got %h want 08", d); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.m = M_SEQ;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b want 1", bus.ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    tests++; if (bus.det !== 8'h00) begin fails++; $display("FAIL rmid_det got %h want 00", bus.det); end
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL rmid_ovf got %b want 0", bus.ovf); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rmid_done got %b want 0", bus.done); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL rmid_no_done got %0d pulses want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int lats [2];
    logic [7:0] dets [2];
    logic rdy13 = 1'b1, rdy14 = 1'b0, busy15 = 1'b0;
    lats[0] = -1; lats[1] = -1; dets[0] = 8'h00; dets[1] = 8'h00;
    @(negedge clk);
    bus.start = 1'b1; bus.m = M_SEQ;
    @(negedge clk);
    bus.m = M_MIN;
    for (int k = 1; k <= 35; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.done === 1'b1) begin
        if (ndone < 2) begin lats[ndone] = k; dets[ndone] = bus.det; end
        ndone++;
      end
      if (k == 13) rdy13 = bus.ready;
      if (k == 14) rdy14 = bus.ready;
      if (k == 15) begin busy15 = bus.busy; bus.start = 1'b0; end
    end
    tests++; if (rdy13 !== 1'b0) begin fails++; $display("FAIL b2b_ready_t13 got %b want 0", rdy13); end
    tests++; if (rdy14 !== 1'b1) begin fails++; $display("FAIL b2b_ready_t14 got %b want 1", rdy14); end
    tests++; if (busy15 !== 1'b1) begin fails++; $display("FAIL b2b_busy_t15 got %b want 1", busy15); end
    tests++; if (ndone !== 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
    tests++; if (lats[0] !== 13 || dets[0] !== 8'hFD) begin
      fails++; $display("FAIL b2b_first got lat=%0d det=%h want lat=13 det=fd", lats[0], dets[0]);
    end
    tests++; if (lats[1] !== 27 || dets[1] !== 8'h80) begin
      fails++; $display("FAIL b2b_second got lat=%0d det=%h want lat=27 det=80", lats[1], dets[1]);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.m     = '0;
    test_reset();
    test_identity();
    test_matrices();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/det3_seq.md
Name: det3_seq

Overview:
- Sequential 3x3 signed determinant engine for the matrix coprocessor. It time-shares one 8-bit signed multiplier across all 12 partial products instead of instantiating 12 multipliers.
- Accepts a packed matrix through a start/ready handshake, runs a fixed 12-step schedule, and returns an 8-bit determinant, an overflow flag and a one-cycle done pulse.
- Sits between the coprocessor instruction decoder and the result register file, as the area-reduced determinant path.

Parameters:
- DATA_W, 8, signed element width and result width.
- ACC_W, 12, signed accumulator width (fixed; must be at least DATA_W+3).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when ready=1.
- m  in  9*DATA_W  packed row-major matrix. Element (r,c) is at bits [9*DATA_W-1-DATA_W*(3r+c) -: DATA_W], so a00 is in the MSBs and a22 in the LSBs.
- ready  out  1  high only in IDLE.
- busy  out  1  high in MUL.
- done  out  1  one-cycle pulse when det/ovf are updated.
- det  out  DATA_W  signed result, low DATA_W bits of the accumulator.
- ovf  out  1  overflow for the last completed operation.

Behaviour:
- Reset:
  - Enters IDLE; ready=1, busy=0, done=0, det=0, ovf=0.
  - Clears step counter, accumulator and sticky overflow.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE -> MUL -> DONE -> IDLE.
- IDLE:
  - On start=1, latch m into an internal register, clear the accumulator and sticky ovf, set step=0, go to MUL.
  - m is not sampled again until the next accepted start.
- Term table, indexed t=0..5 as (x, y, z, sign):
  - t0: (a00, a11, a22, +)
  - t1: (a01, a12, a20, +)
  - t2: (a02, a10, a21, +)
  - t3: (a01, a10, a22, -)
  - t4: (a00, a12, a21, -)
  - t5: (a02, a11, a20, -)
- MUL, step k=0..11, one multiply per cycle, t=k/2:
  - Even k: partial <= trunc_DATA_W(x*y).
  - Odd k: p = trunc_DATA_W(partial*z); acc <= acc ± sign-extended p.
  - Any product outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] sets sticky ovf.
  - Truncation order is fixed: the truncated first product feeds the second multiply.
- After step 11, go to DONE:
  - det <= acc[DATA_W-1:0].
  - ovf <= sticky_ovf OR (acc outside the DATA_W signed range).
  - done=1 for that single cycle.
- DONE always returns to IDLE on the next edge.
- Latency:
  - Start sampled at edge of cycle T.
  - Steps occupy cycles T+1..T+12.
  - done, det, ovf valid in T+13.
  - ready=1 again in T+14.
  - Throughput: one determinant per 14 cycles.
- start while busy or in DONE: ignored; no queuing.
- det and ovf hold their values between done pulses.
- Accumulator arithmetic: full ACC_W signed, no saturation. Maximum magnitude is 6*128 = 768, which fits in 12 bits.
- No X propagation: all registers are reset, and the operand mux defaults to 0.

Decomposition:
- Shared package det3_seq_pkg holds:
  - State enum (IDLE, MUL, DONE).
  - Term table as localparam element indices and sign bits.
  - Constants DATA_W=8, ACC_W=12, N_STEPS=12.
- One natural sub-module, det_mul_unit: combinational DATA_W x DATA_W signed multiply producing a truncated product and a range-overflow flag. It is instantiated once; the FSM muxes its operands by step.

Test Plan:
- Identity (a00=a11=a22=1, rest 0), start at T -> done only in T+13, det=1, ovf=0, ready=0 for T+1..T+13.
- Matrix [2,1,0;1,3,1;0,1,2] -> det=8, ovf=0.
- Matrix [-1,0,0;0,5,0;0,0,5] -> det=-25 (0xE7), ovf=0.
- Product overflow: a00=a11=a22=16, rest 0 -> 16*16=256 out of range, truncated to 0 -> det=0, ovf=1.
- Sum overflow: a00=a11=a22=5, a01=a12=a20=2, rest 0 -> acc=133 -> det=-123 (0x85), ovf=1.
- Control cases:
  - start pulsed during step 4 -> ignored; the single done carries the original result.
  - rst during step 5 -> next cycle ready=1, busy=0, det=0, ovf=0, no done.
  - Back-to-back starts -> second start accepted in T+14, not before.
